// File: rtl/audio_pkg.sv
// Shared audio-path types and default parameters for the I2S controller.
package audio_pkg;

  localparam int unsigned RESOLUTION = 24;
  localparam int unsigned SCLK_DIV   = 4;
  localparam int unsigned FRAME_BITS = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } i2s_ctrl_state_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit/word clock generator: SCLK divider, per-half-frame bit counter and LRCK.
module i2s_clk_gen #(
  parameter int unsigned SCLK_DIV   = audio_pkg::SCLK_DIV,
  parameter int unsigned FRAME_BITS = audio_pkg::FRAME_BITS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sclk,
  output logic lrck,
  output logic fall_stb,
  output logic frame_stb,
  output logic cap_stb
);

  localparam int unsigned DIV_W = $clog2(SCLK_DIV);
  localparam int unsigned BIT_W = $clog2(FRAME_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             div_wrap;

  assign div_wrap = (div_cnt == DIV_LAST);
  assign fall_stb = run && div_wrap && sclk;

  // Position qualifiers; they mark a single edge only when combined with fall_stb.
  assign frame_stb = lrck && (bit_cnt == BIT_LAST);
  assign cap_stb   = !lrck && (bit_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      lrck    <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      lrck    <= 1'b0;
    end else begin
      if (div_wrap) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      // LRCK flips only on a falling SCLK toggle, at the half-frame wrap.
      if (fall_stb) begin
        if (bit_cnt == BIT_LAST) begin
          bit_cnt <= '0;
          lrck    <= ~lrck;
        end else begin
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/i2s_rx_ctrl.sv
// I2S receive master controller: clock generation, frame-aligned start/stop,
// once-per-frame sample capture and valid/ready delivery with overflow flag.
module i2s_rx_ctrl #(
  parameter int unsigned RESOLUTION = audio_pkg::RESOLUTION,
  parameter int unsigned SCLK_DIV   = audio_pkg::SCLK_DIV,
  parameter int unsigned FRAME_BITS = audio_pkg::FRAME_BITS
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  enable,
  output logic                  SCLK,
  output logic                  LRCK,
  input  logic [RESOLUTION-1:0] dec_L,
  input  logic [RESOLUTION-1:0] dec_R,
  output logic [RESOLUTION-1:0] s_L,
  output logic [RESOLUTION-1:0] s_R,
  output logic                  s_valid,
  input  logic                  s_ready,
  output logic                  overflow,
  output logic                  busy
);

  import audio_pkg::*;

  i2s_ctrl_state_t state, state_next;

  logic clk_run;
  logic fall_stb, frame_stb, cap_stb;
  logic boundary, capture, start;

  assign clk_run  = (state != ST_IDLE);
  assign boundary = fall_stb && frame_stb;

  i2s_clk_gen #(
    .SCLK_DIV   (SCLK_DIV),
    .FRAME_BITS (FRAME_BITS)
  ) u_clk_gen (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .run       (clk_run),
    .sclk      (SCLK),
    .lrck      (LRCK),
    .fall_stb  (fall_stb),
    .frame_stb (frame_stb),
    .cap_stb   (cap_stb)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next state plus capture/start qualifiers; stop only takes effect at a frame boundary.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    capture    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (enable) begin
          state_next = ST_PRIME;
          start      = 1'b1;
        end
      end
      ST_PRIME: begin
        if (!enable)       state_next = ST_DRAIN;
        else if (boundary) state_next = ST_RUN;
      end
      ST_RUN: begin
        capture = fall_stb && cap_stb;
        if (!enable) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        capture = fall_stb && cap_stb;
        if (boundary) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Capture register and handshake; a pending pair survives into IDLE until taken.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s_L      <= '0;
      s_R      <= '0;
      s_valid  <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      busy <= (state_next != ST_IDLE);
      if (start) overflow <= 1'b0;
      if (capture) begin
        s_L     <= dec_L;
        s_R     <= dec_R;
        s_valid <= 1'b1;
        if (s_valid && !s_ready) overflow <= 1'b1;
      end else if (s_valid && s_ready) begin
        s_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Directed bench for i2s_rx_ctrl with SCLK_DIV=2, FRAME_BITS=32.
module tb_i2s_rx_ctrl;

  localparam int unsigned RES = 24;

  logic           CLK = 1'b0;
  logic           RESET_N = 1'b0;
  logic           enable = 1'b0;
  logic           s_ready = 1'b0;
  logic           SCLK, LRCK, s_valid, overflow, busy;
  logic [RES-1:0] dec_L = 24'hBADBAD;
  logic [RES-1:0] dec_R = 24'hDEAD00;
  logic [RES-1:0] s_L, s_R;

  int checks = 0;
  int errors = 0;
  int t = 0;

  always #5 CLK = ~CLK;

  i2s_rx_ctrl #(
    .RESOLUTION (RES),
    .SCLK_DIV   (2),
    .FRAME_BITS (32)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .enable   (enable),
    .SCLK     (SCLK),
    .LRCK     (LRCK),
    .dec_L    (dec_L),
    .dec_R    (dec_R),
    .s_L      (s_L),
    .s_R      (s_R),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .overflow (overflow),
    .busy     (busy)
  );

  // Decoder model: presents frame k's words from the first SCLK rise of frame k+1.
  logic [RES-1:0] pat_l [8];
  logic [RES-1:0] pat_r [8];
  int   fidx = 0;
  logic lr_last = 1'b0;

  always @(posedge SCLK) begin
    if (!LRCK && lr_last) begin
      dec_L = pat_l[fidx];
      dec_R = pat_r[fidx];
      if (fidx < 7) fidx++;
    end
    lr_last = LRCK;
  end

  // Transfer log.
  int             acc_cnt = 0;
  logic [RES-1:0] acc_l = '0;
  always @(negedge CLK) begin
    if (RESET_N && s_valid && s_ready) begin
      acc_cnt++;
      acc_l = s_L;
    end
  end

  // LRCK may only move together with an SCLK 1->0 step.
  logic mon_en = 1'b0;
  logic p_sclk = 1'b0;
  logic p_lrck = 1'b0;
  always @(posedge CLK) begin
    #1;
    if (mon_en && (LRCK !== p_lrck)) begin
      checks++;
      if (!(p_sclk === 1'b1 && SCLK === 1'b0)) begin
        errors++;
        $display("FAIL lrck_on_fall t=%0d sclk %b->%b lrck %b->%b", t, p_sclk, SCLK, p_lrck, LRCK);
      end
    end
    p_sclk = SCLK;
    p_lrck = LRCK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got %0h expected %0h", name, t, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    t++;
  endtask

  task automatic run_to(input int target);
    while (t < target) tick();
  endtask

  typedef struct {
    int             tt;
    logic           sclk;
    logic           lrck;
    logic           valid;
    logic           busy;
    logic [RES-1:0] sl;
    logic [RES-1:0] sr;
  } vec_t;

  function automatic vec_t mk(input int tt, input logic sc, input logic lr, input logic va,
                              input logic bu, input logic [RES-1:0] sl, input logic [RES-1:0] sr);
    vec_t v;
    v.tt = tt; v.sclk = sc; v.lrck = lr; v.valid = va; v.busy = bu; v.sl = sl; v.sr = sr;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    pat_l[0] = 24'hA5A5A5; pat_r[0] = 24'h5A5A5A;
    pat_l[1] = 24'hA5A5A5; pat_r[1] = 24'h5A5A5A;
    pat_l[2] = 24'h123456; pat_r[2] = 24'h654321;
    pat_l[3] = 24'h0ABCDE; pat_r[3] = 24'hFEDCBA;
    pat_l[4] = 24'hC0FFEE; pat_r[4] = 24'hBEEF01;
    for (int i = 5; i < 8; i++) begin
      pat_l[i] = 24'h111111; pat_r[i] = 24'h222222;
    end

    // Offsets are CLK edges after enable is first sampled.
    vecs.push_back(mk(0,   1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 24'h0));
    vecs.push_back(mk(1,   1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 24'h0));
    vecs.push_back(mk(2,   1'b1, 1'b0, 1'b0, 1'b1, 24'h0, 24'h0));
    vecs.push_back(mk(3,   1'b1, 1'b0, 1'b0, 1'b1, 24'h0, 24'h0));
    vecs.push_back(mk(4,   1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 24'h0));
    vecs.push_back(mk(5,   1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 24'h0));
    vecs.push_back(mk(127, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0, 24'h0));
    vecs.push_back(mk(128, 1'b0, 1'b1, 1'b0, 1'b1, 24'h0, 24'h0));
    vecs.push_back(mk(129, 1'b0, 1'b1, 1'b0, 1'b1, 24'h0, 24'h0));
    vecs.push_back(mk(130, 1'b1, 1'b1, 1'b0, 1'b1, 24'h0, 24'h0));
    vecs.push_back(mk(255, 1'b1, 1'b1, 1'b0, 1'b1, 24'h0, 24'h0));
    vecs.push_back(mk(256, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 24'h0));
    vecs.push_back(mk(259, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0, 24'h0));
    vecs.push_back(mk(260, 1'b0, 1'b0, 1'b1, 1'b1, 24'hA5A5A5, 24'h5A5A5A));
    vecs.push_back(mk(261, 1'b0, 1'b0, 1'b0, 1'b1, 24'hA5A5A5, 24'h5A5A5A));
    vecs.push_back(mk(400, 1'b0, 1'b1, 1'b0, 1'b1, 24'hA5A5A5, 24'h5A5A5A));
    vecs.push_back(mk(515, 1'b1, 1'b0, 1'b0, 1'b1, 24'hA5A5A5, 24'h5A5A5A));
    vecs.push_back(mk(516, 1'b0, 1'b0, 1'b1, 1'b1, 24'hA5A5A5, 24'h5A5A5A));

    // Reset values.
    #12;
    chk("rst_sclk", 32'(SCLK), 32'h0);
    chk("rst_lrck", 32'(LRCK), 32'h0);
    chk("rst_sl", 32'(s_L), 32'h0);
    chk("rst_sr", 32'(s_R), 32'h0);
    chk("rst_valid", 32'(s_valid), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    mon_en  = 1'b1;
    tick(); tick(); tick();
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_sclk", 32'(SCLK), 32'h0);

    // Start: the next edge samples enable.
    s_ready = 1'b1;
    enable  = 1'b1;
    @(posedge CLK); #1;
    t = 0;
    foreach (vecs[i]) begin
      run_to(vecs[i].tt);
      chk("tab_sclk", 32'(SCLK), 32'(vecs[i].sclk));
      chk("tab_lrck", 32'(LRCK), 32'(vecs[i].lrck));
      chk("tab_valid", 32'(s_valid), 32'(vecs[i].valid));
      chk("tab_busy", 32'(busy), 32'(vecs[i].busy));
      chk("tab_sl", 32'(s_L), 32'(vecs[i].sl));
      chk("tab_sr", 32'(s_R), 32'(vecs[i].sr));
      chk("tab_ovf", 32'(overflow), 32'h0);
    end
    chk("acc_first_cnt", 32'(acc_cnt), 32'd1);
    chk("acc_first_l", 32'(acc_l), 32'hA5A5A5);

    // Ready returns exactly on a capture edge: old pair leaves, new pair loads.
    s_ready = 1'b0;
    run_to(771);
    chk("hold_valid", 32'(s_valid), 32'h1);
    chk("hold_acc_cnt", 32'(acc_cnt), 32'd1);
    s_ready = 1'b1;
    run_to(772);
    chk("same_edge_valid", 32'(s_valid), 32'h1);
    chk("same_edge_sl", 32'(s_L), 32'h123456);
    chk("same_edge_sr", 32'(s_R), 32'h654321);
    chk("same_edge_ovf", 32'(overflow), 32'h0);
    s_ready = 1'b0;
    run_to(773);
    chk("same_edge_acc", 32'(acc_cnt), 32'd2);

    // Pending pair overwritten by the next capture.
    run_to(1027);
    chk("pre_ovf", 32'(overflow), 32'h0);
    chk("pre_ovf_sl", 32'(s_L), 32'h123456);
    run_to(1028);
    chk("ovf_set", 32'(overflow), 32'h1);
    chk("ovf_sl", 32'(s_L), 32'h0ABCDE);
    chk("ovf_sr", 32'(s_R), 32'hFEDCBA);
    s_ready = 1'b1;
    run_to(1029);
    chk("ovf_sticky", 32'(overflow), 32'h1);
    chk("ovf_drain_valid", 32'(s_valid), 32'h0);
    chk("ovf_acc_l", 32'(acc_l), 32'h0ABCDE);
    chk("ovf_acc_cnt", 32'(acc_cnt), 32'd3);
    s_ready = 1'b0;

    // Stop mid right half; clocks finish the frame, pending pair is held.
    run_to(1284);
    chk("last_cap_sl", 32'(s_L), 32'hC0FFEE);
    run_to(1447);
    enable = 1'b0;
    run_to(1448);
    chk("drain_busy", 32'(busy), 32'h1);
    run_to(1535);
    chk("pre_stop_busy", 32'(busy), 32'h1);
    chk("pre_stop_sclk", 32'(SCLK), 32'h1);
    chk("pre_stop_lrck", 32'(LRCK), 32'h1);
    run_to(1536);
    chk("stop_busy", 32'(busy), 32'h0);
    chk("stop_sclk", 32'(SCLK), 32'h0);
    chk("stop_lrck", 32'(LRCK), 32'h0);
    chk("stop_valid", 32'(s_valid), 32'h1);
    run_to(1600);
    chk("idle_hold_sclk", 32'(SCLK), 32'h0);
    chk("idle_hold_lrck", 32'(LRCK), 32'h0);
    chk("idle_hold_valid", 32'(s_valid), 32'h1);
    chk("idle_hold_sl", 32'(s_L), 32'hC0FFEE);
    s_ready = 1'b1;
    run_to(1601);
    chk("idle_take_valid", 32'(s_valid), 32'h0);
    chk("idle_take_acc", 32'(acc_l), 32'hC0FFEE);
    chk("idle_take_cnt", 32'(acc_cnt), 32'd4);
    chk("idle_ovf_kept", 32'(overflow), 32'h1);

    // Restart clears overflow; then build state and reset asynchronously mid-frame.
    s_ready = 1'b0;
    lr_last = 1'b0;
    fidx    = 0;
    enable  = 1'b1;
    @(posedge CLK); #1;
    t = 0;
    chk("restart_busy", 32'(busy), 32'h1);
    chk("restart_ovf", 32'(overflow), 32'h0);
    run_to(516);
    chk("r2_ovf", 32'(overflow), 32'h1);
    run_to(650);
    chk("pre_rst_sclk", 32'(SCLK), 32'h1);
    chk("pre_rst_lrck", 32'(LRCK), 32'h1);
    chk("pre_rst_valid", 32'(s_valid), 32'h1);
    chk("pre_rst_sl", 32'(s_L), 32'hA5A5A5);
    mon_en = 1'b0;
    enable = 1'b0;
    #2;
    RESET_N = 1'b0;
    #1;
    chk("arst_sclk", 32'(SCLK), 32'h0);
    chk("arst_lrck", 32'(LRCK), 32'h0);
    chk("arst_sl", 32'(s_L), 32'h0);
    chk("arst_sr", 32'(s_R), 32'h0);
    chk("arst_valid", 32'(s_valid), 32'h0);
    chk("arst_ovf", 32'(overflow), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    tick();
    RESET_N = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_busy", 32'(busy), 32'h0);
    chk("post_rst_sclk", 32'(SCLK), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_rx_ctrl.md
# i2s_rx_ctrl

I2S receive-side master controller for the MAX-10 audio path. It generates the bit clock (SCLK) and word clock (LRCK) that drive the I2S decoder and the external codec from a single system clock. It samples the decoder's parallel left/right words at a safe point in each frame and hands stereo samples to the downstream processing chain over a valid/ready handshake. It also sequences start/stop on whole-frame boundaries and flags sample overflow.

## Interface
- `RESOLUTION`, 24: sample word width; must equal the decoder's `RESOLUTION`.
- `SCLK_DIV`, 4: CLK cycles per SCLK half-period; legal range ≥ 2.
- `FRAME_BITS`, 32: SCLK periods per channel half-frame; legal range ≥ `RESOLUTION`+1.

Ports:
- `CLK` input 1: system clock. One clock domain; every register is clocked on the rising edge of `CLK`.
- `RESET_N` input 1: asynchronous, active-low reset.
- `enable` input 1: level signal requesting that the I2S clocks run.
- `SCLK` output 1: generated bit clock, registered.
- `LRCK` output 1: generated word clock; 0 = left, 1 = right; registered.
- `dec_L` input `RESOLUTION`: decoder `data_out_L`.
- `dec_R` input `RESOLUTION`: decoder `data_out_R`.
- `s_L` output `RESOLUTION`: left sample presented downstream.
- `s_R` output `RESOLUTION`: right sample presented downstream.
- `s_valid` output 1: sample pair is valid.
- `s_ready` input 1: downstream accepts the sample pair.
- `overflow` output 1: sticky; set when a sample pair is lost. Cleared only by reset or by a new start.
- `busy` output 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, PRIME, RUN, DRAIN.
  - IDLE → PRIME when `enable`=1. On this transition `overflow` is cleared.
  - PRIME → RUN at the first frame boundary.
  - RUN → DRAIN when `enable`=0 is sampled.
  - DRAIN → IDLE at the next frame boundary.
  - PRIME → DRAIN when `enable`=0 is sampled.
- Frame boundary: the SCLK falling edge on which `LRCK` would change from 1 to 0.
- Divider: counter `div_cnt` runs 0..`SCLK_DIV`-1. When it wraps, `SCLK` toggles. In IDLE, `div_cnt`=0 and `SCLK`=0.
- Bit counter: `bit_cnt` runs 0..`FRAME_BITS`-1 and advances on each SCLK falling toggle (1→0). When it wraps from `FRAME_BITS`-1 to 0, `LRCK` toggles on the same CLK edge. `LRCK` therefore always changes coincident with a falling edge of `SCLK`.
- Capture point: the falling toggle that sets `bit_cnt` to 1 while `LRCK`=0. At this point the decoder has already registered the previous frame's L/R words on the preceding SCLK rise.
- In PRIME, captures are discarded; the first frame's decoder data is undefined.
- In RUN and DRAIN, a capture loads `s_L`←`dec_L` and `s_R`←`dec_R`, and sets `s_valid`=1.
- Handshake: a transfer occurs on a CLK edge where `s_valid`=1 and `s_ready`=1. After the transfer, `s_valid`=0 unless a capture occurs on the same edge; in that case the new data loads and `s_valid` stays 1.
- Overflow: if a capture occurs while `s_valid`=1 and `s_ready`=0, the old pair is overwritten and `overflow` is set.
- `enable` toggling within a frame has no effect until the frame boundary. A re-assert of `enable` during DRAIN is ignored; after IDLE, start again.

## Timing
- Reset values: `SCLK`=0, `LRCK`=0, `s_L`=0, `s_R`=0, `s_valid`=0, `overflow`=0, `busy`=0, state IDLE, all counters 0.
- Reset asserted mid-frame forces the reset values immediately, asynchronously. No drain occurs.
- Start latency: with `enable` sampled high at edge N, the state is PRIME and `busy`=1 after edge N. The first `SCLK` rise occurs at edge N+`SCLK_DIV`.
- SCLK period is 2·`SCLK_DIV` CLK cycles. A frame is 2·`FRAME_BITS`·2·`SCLK_DIV` CLK cycles.
- A capture occurs exactly once per frame, on the CLK edge of the qualifying SCLK falling toggle.
- The first `s_valid` rises at the capture point of the second frame after start.
- Stop behaviour: `SCLK` and `LRCK` hold at 0 from the final frame boundary onward. `busy` falls on that same edge.
- A pending `s_valid` is held through IDLE until it is accepted.

## Structure
- Shared package `audio_pkg`:
  - FSM state enum `i2s_ctrl_state_t`.
  - Default constants: `RESOLUTION`, `SCLK_DIV`, `FRAME_BITS`.
- Sub-module `i2s_clk_gen` contains the divider, `bit_cnt`, `SCLK`/`LRCK` generation, and strobe outputs `fall_stb`, `frame_stb` and `cap_stb`.
- The FSM, capture register and handshake logic stay in the top module.

## Test plan
Parameters for all scenarios are `SCLK_DIV`=2 and `FRAME_BITS`=32. The decoder is modelled as a register updated on the SCLK rise that follows each `LRCK` edge.
1. Reset, then `enable`=1 → `SCLK` period is 4 CLK; `LRCK` toggles every 128 CLK; `LRCK` changes only coincident with SCLK 1→0.
2. Serial input L=0xA5A5A5, R=0x5A5A5A with `s_ready`=1 → first frame discarded; `s_valid` pulses once per 256 CLK; `s_L`=0xA5A5A5, `s_R`=0x5A5A5A.
3. `s_ready`=0 for two frames → `s_L` holds the second frame's data; `overflow`=1 and stays 1 after `s_ready` returns to 1.
4. `s_ready` and a capture on the same CLK edge → the old pair is transferred, the new pair is loaded, `s_valid` stays 1, `overflow` stays 0.
5. `enable` deasserted at bit 10 of the right half → clocks continue to the frame boundary; then `SCLK`=`LRCK`=0 and `busy`=0; the final capture is delivered.
6. `RESET_N` pulsed low mid-frame → all outputs take their reset values asynchronously, before the next `CLK` edge.
